// File: rtl/alu_issue_queue_if.sv
// rtl/alu_issue_queue_if.sv - request, ALU drive and result bundle for alu_issue_queue (tag ports with ALU_ISSUE_TAG_EN)
interface alu_issue_queue_if #(
  parameter int data_width = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_func;
  logic [data_width-1:0] in_a;
  logic [data_width-1:0] in_b;
  logic [3:0]            alu_func;
  logic [data_width-1:0] alu_a;
  logic [data_width-1:0] alu_b;
  logic [data_width-1:0] alu_c;
  logic                  alu_ovf;
  logic                  out_valid;
  logic                  out_ready;
  logic [data_width-1:0] out_c;
  logic                  out_ovf;
  logic [3:0]            out_func;
`ifdef ALU_ISSUE_TAG_EN
  logic [3:0]            in_tag;
  logic [3:0]            out_tag;
`endif

  modport slave (
    input  in_valid, in_func, in_a, in_b, alu_c, alu_ovf, out_ready,
`ifdef ALU_ISSUE_TAG_EN
    input  in_tag,
    output out_tag,
`endif
    output in_ready, alu_func, alu_a, alu_b, out_valid, out_c, out_ovf, out_func
  );

  modport master (
    output in_valid, in_func, in_a, in_b, alu_c, alu_ovf, out_ready,
`ifdef ALU_ISSUE_TAG_EN
    output in_tag,
    input  out_tag,
`endif
    input  in_ready, alu_func, alu_a, alu_b, out_valid, out_c, out_ovf, out_func
  );
endinterface

// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - FIFO front end and registered result stage for the 16-bit ALU (optional tags: ALU_ISSUE_TAG_EN)
module alu_issue_queue #(
  parameter int data_width = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       clr_sticky,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf_sticky,
  alu_issue_queue_if.slave           bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [3:0]            func_mem [DEPTH];
  logic [data_width-1:0] a_mem    [DEPTH];
  logic [data_width-1:0] b_mem    [DEPTH];
`ifdef ALU_ISSUE_TAG_EN
  logic [3:0]            tag_mem  [DEPTH];
`endif
  logic                  head_valid;
  logic                  wr_en;
  logic                  load;

  // in_ready comes from the registered count only, so a full queue never bypasses on a pop
  assign head_valid    = (count != '0);
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign wr_en         = bus.in_valid && bus.in_ready && !flush;
  assign bus.out_valid = (state == S_FULL);

  // Present the FIFO head to the ALU; idle operands are forced to zero
  always_comb begin
    bus.alu_func = '0;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    if (head_valid) begin
      bus.alu_func = func_mem[rd_ptr];
      bus.alu_a    = a_mem[rd_ptr];
      bus.alu_b    = b_mem[rd_ptr];
    end
  end

  // Output-stage next state: load when the head exists and the result register is free or being consumed
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (head_valid && (state == S_EMPTY || bus.out_ready)) begin
      load = 1'b1;
    end
    case (state)
      S_EMPTY: if (load) state_nxt = S_FULL;
      S_FULL:  if (!load && bus.out_ready) state_nxt = S_EMPTY;
      default: state_nxt = S_EMPTY;
    endcase
    if (flush) begin
      load      = 1'b0;
      state_nxt = S_EMPTY;
    end
  end

  // Output-stage state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_en);
      rd_ptr <= rd_ptr + PTR_W'(load);
      count  <= count + CNT_W'(wr_en) - CNT_W'(load);
    end
  end

  // Entry storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      func_mem[wr_ptr] <= bus.in_func;
      a_mem[wr_ptr]    <= bus.in_a;
      b_mem[wr_ptr]    <= bus.in_b;
`ifdef ALU_ISSUE_TAG_EN
      tag_mem[wr_ptr]  <= bus.in_tag;
`endif
    end
  end

  // Result register captures the ALU output on load and otherwise holds
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.out_c    <= '0;
      bus.out_ovf  <= 1'b0;
      bus.out_func <= '0;
`ifdef ALU_ISSUE_TAG_EN
      bus.out_tag  <= '0;
`endif
    end else if (load) begin
      bus.out_c    <= bus.alu_c;
      bus.out_ovf  <= bus.alu_ovf;
      bus.out_func <= func_mem[rd_ptr];
`ifdef ALU_ISSUE_TAG_EN
      bus.out_tag  <= tag_mem[rd_ptr];
`endif
    end
  end

  // Sticky overflow: a setting load beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_sticky <= 1'b0;
    end else if (load && bus.alu_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (clr_sticky) begin
      ovf_sticky <= 1'b0;
    end
  end
endmodule
